// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default sample width, frame length and
// the bit-reversal helper used for decimation-in-time input ordering.
package fft_pkg;

    localparam int SAMPLE_W = 16;
    localparam int FRAME_N  = 16;

    // Reverses the low 'aw' bits of v; bits at or above 'aw' come back as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int aw);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < aw) r[aw-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_bank.sv
// One DEPTH x WIDTH register bank with a single synchronous write port and
// the whole array exposed as a flat vector (word w at [w*WIDTH +: WIDTH]).
module frame_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FRAME_N,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_addr,
    input  logic [WIDTH-1:0]       i_data,
    output logic [DEPTH*WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_addr] <= i_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_data[g*WIDTH +: WIDTH] = r_mem[g];
    end

endmodule

// File: rtl/frame_buffer.sv
// Ping-pong frame buffer: streams DEPTH samples into the fill bank and
// presents the completed bank as a parallel frame. Define FRAME_BITREV_EN to
// store samples in bit-reversed word order.
module frame_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FRAME_N
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [WIDTH-1:0]        i_word,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [DEPTH*WIDTH-1:0]  o_frame,
    output logic                    o_frame_valid,
    input  logic                    i_frame_ack,
    output logic                    o_overflow,
    output logic [$clog2(DEPTH):0]  o_fill_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Write side: a sample transfers when i_valid && o_ready on a rising edge;
    // i_valid without o_ready drops the sample. Read side: a frame is released
    // when i_frame_ack && o_frame_valid; an ack without a valid frame is ignored.
    logic [1:0]             r_full;
    logic                   r_wr_bank;
    logic                   r_rd_bank;
    logic [CW-1:0]          r_cnt;
    logic                   r_overflow;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_ack;
    logic [1:0]             w_full_next;
    logic [1:0]             w_we;
    logic [AW-1:0]          w_addr;
    logic [DEPTH*WIDTH-1:0] w_bank0;
    logic [DEPTH*WIDTH-1:0] w_bank1;

    assign w_ready  = !r_full[r_wr_bank];
    assign w_accept = i_valid && w_ready;
    assign w_last   = (r_cnt == CW'(DEPTH - 1));
    assign w_ack    = i_frame_ack && r_full[r_rd_bank];
    assign w_we     = {w_accept && r_wr_bank, w_accept && !r_wr_bank};

`ifdef FRAME_BITREV_EN
    assign w_addr = AW'(bitrev(32'(r_cnt[AW-1:0]), AW));
`else
    assign w_addr = r_cnt[AW-1:0];
`endif

    // Completion and ack can never hit the same bank: one needs it empty, the other full.
    always_comb begin
        w_full_next = r_full;
        if (w_accept && w_last) w_full_next[r_wr_bank] = 1'b1;
        if (w_ack)              w_full_next[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_accept) begin
                if (w_last) begin
                    r_cnt     <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (i_valid && !w_ready) r_overflow <= 1'b1;
            if (w_ack)               r_rd_bank  <= ~r_rd_bank;
        end
    end

    frame_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_we[0]),
        .i_addr (w_addr),
        .i_data (i_word),
        .o_data (w_bank0)
    );

    frame_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_we[1]),
        .i_addr (w_addr),
        .i_data (i_word),
        .o_data (w_bank1)
    );

    assign o_ready       = w_ready;
    assign o_frame       = r_rd_bank ? w_bank1 : w_bank0;
    assign o_frame_valid = r_full[r_rd_bank];
    assign o_overflow    = r_overflow;
    assign o_fill_count  = r_cnt;

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: a frame-queue model compared on every falling edge,
// plus literal checks at the key points. Honors FRAME_BITREV_EN like the DUT.
module tb_frame_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int FW    = DEPTH * WIDTH;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [WIDTH-1:0] i_word;
    logic             i_valid;
    logic             i_frame_ack;
    logic             o_ready;
    logic [FW-1:0]    o_frame;
    logic             o_frame_valid;
    logic             o_overflow;
    logic [4:0]       o_fill_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    frame_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_word        (i_word),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ack   (i_frame_ack),
        .o_overflow    (o_overflow),
        .o_fill_count  (o_fill_count)
    );

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word_of(input logic [FW-1:0] f, input int w);
        return f[w*WIDTH +: WIDTH];
    endfunction

    // Word slot that the n-th sample of a frame should occupy.
    function automatic int slot_of(input int n);
`ifdef FRAME_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) if (((n >> b) & 1) != 0) r = r | (1 << (3 - b));
        return r;
`else
        return n;
`endif
    endfunction

    // Model: samples of the frame being filled, and completed frames awaiting
    // the consumer (oldest first, at most two since there are two banks).
    logic [WIDTH-1:0] part_q [$];
    logic [FW-1:0]    frm_q  [$];
    bit               m_ovf;
    int               m_pre;
    logic [FW-1:0]    m_tmp;

    always @(posedge clk) begin
        if (i_rst) begin
            part_q.delete();
            frm_q.delete();
            m_ovf = 1'b0;
        end else begin
            m_pre = frm_q.size();
            if (i_valid) begin
                if (m_pre == 2) begin
                    m_ovf = 1'b1;
                end else begin
                    part_q.push_back(i_word);
                    if (part_q.size() == DEPTH) begin
                        m_tmp = '0;
                        for (int n = 0; n < DEPTH; n++) m_tmp[slot_of(n)*WIDTH +: WIDTH] = part_q[n];
                        frm_q.push_back(m_tmp);
                        part_q.delete();
                    end
                end
            end
            if (i_frame_ack && m_pre > 0) void'(frm_q.pop_front());
        end
    end

    // Outputs depend only on registered state, so falling-edge sampling is stable.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", FW'(o_ready), FW'(frm_q.size() < 2));
            chk("frame_valid", FW'(o_frame_valid), FW'(frm_q.size() > 0));
            chk("overflow", FW'(o_overflow), FW'(m_ovf));
            chk("fill_count", FW'(o_fill_count), FW'(part_q.size()));
            if (frm_q.size() > 0) chk("frame", o_frame, frm_q[0]);
        end
    end

    task automatic drive(input bit rst, input bit v, input logic [WIDTH-1:0] w, input bit a);
        @(negedge clk);
        i_rst       = rst;
        i_valid     = v;
        i_word      = w;
        i_frame_ack = a;
    endtask

    int beef_cnt;

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_word = '0; i_frame_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst  = 1'b0;
        chk_en = 1'b1;
        chk("reset_frame", o_frame, '0);
        chk("reset_valid", FW'(o_frame_valid), FW'(0));
        chk("reset_ready", FW'(o_ready), FW'(1));
        chk("reset_overflow", FW'(o_overflow), FW'(0));
        chk("reset_fill", FW'(o_fill_count), FW'(0));

        // Frame 1: samples 0x0001..0x0010
        for (int n = 0; n < DEPTH; n++) drive(0, 1, WIDTH'(n + 1), 0);
        drive(0, 0, '0, 0);
        chk("f1_valid", FW'(o_frame_valid), FW'(1));
        chk("f1_fill", FW'(o_fill_count), FW'(0));
`ifdef FRAME_BITREV_EN
        chk("f1_w1", FW'(word_of(o_frame, 1)), FW'(16'h0009));
        chk("f1_w8", FW'(word_of(o_frame, 8)), FW'(16'h0002));
`else
        chk("f1_w0", FW'(word_of(o_frame, 0)), FW'(16'h0001));
        chk("f1_w8", FW'(word_of(o_frame, 8)), FW'(16'h0009));
`endif
        chk("f1_w15", FW'(word_of(o_frame, 15)), FW'(16'h0010));

        // Frame 2 completes in the same cycle frame 1 is acked
        for (int n = 0; n < DEPTH; n++) drive(0, 1, WIDTH'(16'h0011 + n), n == DEPTH - 1);
        drive(0, 0, '0, 0);
        chk("f2_valid", FW'(o_frame_valid), FW'(1));
        chk("f2_w0", FW'(word_of(o_frame, 0)), FW'(16'h0011));
        chk("f2_ready", FW'(o_ready), FW'(1));

        // Frame 3 fills the other bank with no ack; then an overflow sample
        for (int n = 0; n < DEPTH; n++) drive(0, 1, WIDTH'(16'h0021 + n), 0);
        drive(0, 1, 16'hBEEF, 0);
        drive(0, 0, '0, 0);
        chk("ovf_ready", FW'(o_ready), FW'(0));
        chk("ovf_flag", FW'(o_overflow), FW'(1));
        chk("ovf_fill", FW'(o_fill_count), FW'(0));
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 0);
        chk("f3_w0", FW'(word_of(o_frame, 0)), FW'(16'h0021));
        chk("f3_ready", FW'(o_ready), FW'(1));
        beef_cnt = 0;
        for (int w = 0; w < DEPTH; w++) if (word_of(o_frame, w) == 16'hBEEF) beef_cnt++;
        chk("f3_no_beef", FW'(beef_cnt), FW'(0));
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 0);
        chk("drained_valid", FW'(o_frame_valid), FW'(0));

        // Reset in the middle of a fill
        for (int n = 0; n < 7; n++) drive(0, 1, WIDTH'(16'h0040 + n), 0);
        drive(1, 1, 16'h0047, 0);
        drive(0, 0, '0, 0);
        chk("mid_rst_fill", FW'(o_fill_count), FW'(0));
        chk("mid_rst_overflow", FW'(o_overflow), FW'(0));
        chk("mid_rst_frame", o_frame, '0);
        chk("mid_rst_ready", FW'(o_ready), FW'(1));

        // Stray ack with nothing presented, then a fresh frame
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 0);
        chk("stray_ack_valid", FW'(o_frame_valid), FW'(0));
        for (int n = 0; n < DEPTH; n++) drive(0, 1, WIDTH'(16'h0051 + n), 0);
        drive(0, 0, '0, 0);
        chk("f4_valid", FW'(o_frame_valid), FW'(1));
        chk("f4_w0", FW'(word_of(o_frame, 0)), FW'(16'h0051));
        chk("f4_w15", FW'(word_of(o_frame, 15)), FW'(16'h0060));

        // A few random-gap samples into the other bank exercise partial fills
        for (int n = 0; n < 6; n++) drive(0, 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 65535)), 0);
        drive(0, 0, '0, 1);
        repeat (3) drive(0, 0, '0, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
